// File: rtl/imem_loadable.sv
// imem_loadable: instruction RAM filled over a valid/ready load port, then fetched by the CPU
module imem_loadable #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          iaddr,
    input  logic                       ird_en,
    output logic [DATA_W-1:0]          idata,
    output logic                       ivalid,
    output logic                       stall,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    output logic                       ld_done,
    output logic                       ld_err,
    output logic [$clog2(DEPTH):0]     ld_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-2:0]   idx;
    logic [ADDR_W-2:0]   cnt_ext;
    logic                accept;
    logic                last_slot;
    logic                in_range;
    logic                fetch;
    logic                unused_bit0;

    assign idx         = iaddr[ADDR_W-1:1];
    assign unused_bit0 = iaddr[0];
    assign cnt_ext     = {{(ADDR_W-1-CW){1'b0}}, ld_count};
    assign in_range    = idx < cnt_ext;
    assign accept      = ld_valid && ld_ready;
    assign last_slot   = ld_count == CW'(DEPTH - 1);
    assign fetch       = state == RUN && !ld_start && ird_en;
    assign stall       = state != RUN;

    // Next-state decode: a load ends on ld_last or when the last slot is written.
    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   if (ld_start) state_n = LOAD;
            LOAD:    if (accept && (ld_last || last_slot)) state_n = RUN;
            RUN:     if (ld_start) state_n = LOAD;
            default: state_n = EMPTY;
        endcase
    end

    // State register plus registered load-port handshake and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
            ld_count <= '0;
        end else begin
            state    <= state_n;
            ld_ready <= state_n == LOAD;
            ld_done  <= state == LOAD && state_n == RUN;
            if (state != LOAD && state_n == LOAD)
                ld_count <= '0;
            else if (accept)
                ld_count <= ld_count + 1'b1;
            if (state == RUN && ld_start)
                ld_err <= 1'b0;
            else if (accept && last_slot && !ld_last)
                ld_err <= 1'b1;
        end
    end

    // Storage is not reset; ld_count gates what is readable.
    always_ff @(posedge clk) begin
        if (accept)
            mem[ld_count[AW-1:0]] <= ld_data;
    end

    // Registered fetch; words beyond the loaded program read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idata  <= '0;
            ivalid <= 1'b0;
        end else begin
            ivalid <= fetch;
            if (fetch)
                idata <= in_range ? mem[idx[AW-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: randomized and directed checks of imem_loadable against a behavioural model
module tb_imem_loadable;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] iaddr = '0;
    logic        ird_en = 1'b0;
    logic [15:0] idata;
    logic        ivalid;
    logic        stall;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic [6:0]  ld_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: program array, word count, error flag, mode and expected fetch outputs
    logic [15:0] m_mem [DEPTH];
    int          m_count = 0;
    bit          m_err = 0;
    bit          m_load = 0;
    bit          m_run = 0;
    logic [15:0] exp_idata = '0;
    logic        exp_ivalid = 1'b0;

    imem_loadable #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .iaddr(iaddr), .ird_en(ird_en), .idata(idata),
        .ivalid(ivalid), .stall(stall), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done),
        .ld_err(ld_err), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_count = 0;
        m_err = 0;
        m_load = 0;
        m_run = 0;
        exp_idata = '0;
        exp_ivalid = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
        m_count = 0;
        m_err = 0;
        m_load = 1;
        m_run = 0;
        exp_ivalid = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data = d;
        ld_last = last;
        cyc();
        ld_valid = 1'b0;
        ld_last = 1'b0;
        if (m_load) begin
            m_mem[m_count] = d;
            m_count++;
            if (last || m_count == DEPTH) begin
                m_err = !last;
                m_load = 0;
                m_run = 1;
            end
        end
    endtask

    task automatic fetch(input logic [15:0] a, input bit en);
        int idx;
        iaddr = a;
        ird_en = en;
        cyc();
        ird_en = 1'b0;
        idx = int'(a) / 2;
        exp_ivalid = en && m_run;
        if (en && m_run)
            exp_idata = (idx < m_count) ? m_mem[idx] : 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        cyc();
        cyc();
        n_tests++;
        if ({idata, ivalid, ld_ready, ld_done, ld_err, ld_count, stall} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: idata=%h ivalid=%b rdy=%b done=%b err=%b cnt=%0d stall=%b, need all 0 and stall=1",
                     idata, ivalid, ld_ready, ld_done, ld_err, ld_count, stall);
        end
        rst_n = 1'b1;
        cyc();
        fetch(16'h0000, 1'b1);
        n_tests++;
        if (ivalid !== 1'b0 || idata !== 16'h0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_fetch: ivalid=%b idata=%h stall=%b, need 0 0000 1", ivalid, idata, stall);
        end
    endtask

    task automatic test_load_fetch();
        logic [15:0] prog [6] = '{16'h80FA, 16'h0E3C, 16'h7F90, 16'h8164, 16'h8FD2, 16'h7F78};
        start_load();
        n_tests++;
        if (ld_ready !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_start: ld_ready=%b stall=%b, need 1 1", ld_ready, stall);
        end
        for (int i = 0; i < 6; i++) begin
            beat(prog[i], i == 5);
            if (i == 1)
                cyc();
            if (i < 5) begin
                n_tests++;
                if (ld_count !== 7'(i + 1) || stall !== 1'b1 || ld_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_progress: beat %0d cnt=%0d stall=%b done=%b, need %0d 1 0", i, ld_count, stall, ld_done, i + 1);
                end
            end
        end
        n_tests++;
        if (ld_count !== 7'd6 || ld_done !== 1'b1 || stall !== 1'b0 || ld_ready !== 1'b0 || ld_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_end: cnt=%0d done=%b stall=%b rdy=%b err=%b, need 6 1 0 0 0", ld_count, ld_done, stall, ld_ready, ld_err);
        end
        cyc();
        n_tests++;
        if (ld_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: ld_done=%b one cycle later, need 0", ld_done);
        end
        fetch(16'h0002, 1'b1);
        n_tests++;
        if (idata !== 16'h0E3C || ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_2: idata=%h ivalid=%b, need 0e3c 1", idata, ivalid);
        end
        fetch(16'h0003, 1'b1);
        n_tests++;
        if (idata !== 16'h0E3C || ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_3: idata=%h ivalid=%b, need 0e3c 1", idata, ivalid);
        end
        fetch(16'h0000, 1'b0);
        n_tests++;
        if (idata !== 16'h0E3C || ivalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold: idata=%h ivalid=%b, need 0e3c 0", idata, ivalid);
        end
    endtask

    task automatic test_out_of_range();
        fetch(16'h000A, 1'b1);
        fetch(16'h000C, 1'b1);
        n_tests++;
        if (idata !== 16'h0 || ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_idx6: idata=%h ivalid=%b, need 0000 1", idata, ivalid);
        end
        fetch(16'h000A, 1'b1);
        fetch(16'h0080, 1'b1);
        n_tests++;
        if (idata !== 16'h0 || ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_idx64: idata=%h ivalid=%b, need 0000 1", idata, ivalid);
        end
    endtask

    task automatic test_async_reset();
        fetch(16'h0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({idata, ivalid, ld_ready, ld_done, ld_err, ld_count, stall} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: idata=%h ivalid=%b rdy=%b done=%b err=%b cnt=%0d stall=%b, need all 0 and stall=1",
                     idata, ivalid, ld_ready, ld_done, ld_err, ld_count, stall);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_overflow();
        logic [15:0] first;
        start_load();
        for (int i = 0; i < DEPTH; i++)
            beat(16'($urandom), 1'b0);
        n_tests++;
        if (stall !== 1'b0 || ld_err !== 1'b1 || ld_count !== 7'd64 || ld_ready !== 1'b0 || ld_done !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: stall=%b err=%b cnt=%0d rdy=%b done=%b, need 0 1 64 0 1", stall, ld_err, ld_count, ld_ready, ld_done);
        end
        first = m_mem[0];
        beat(~first, 1'b0);
        n_tests++;
        if (ld_count !== 7'd64 || m_count != 64) begin
            n_fail++;
            $display("FAIL beat_65: cnt=%0d, need 64", ld_count);
        end
        fetch(16'd126, 1'b1);
        n_tests++;
        if (idata !== exp_idata || ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_idx63: idata=%h ivalid=%b, need %h 1", idata, ivalid, exp_idata);
        end
        fetch(16'd0, 1'b1);
        n_tests++;
        if (idata !== first) begin
            n_fail++;
            $display("FAIL idx0_intact: idata=%h, need %h", idata, first);
        end
    endtask

    task automatic test_reload();
        ld_start = 1'b1;
        ird_en = 1'b1;
        iaddr = 16'h0000;
        cyc();
        ld_start = 1'b0;
        ird_en = 1'b0;
        m_count = 0;
        m_err = 0;
        m_load = 1;
        m_run = 0;
        n_tests++;
        if (ivalid !== 1'b0 || stall !== 1'b1 || ld_err !== 1'b0 || ld_count !== 7'd0 || ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_start: ivalid=%b stall=%b err=%b cnt=%0d rdy=%b, need 0 1 0 0 1", ivalid, stall, ld_err, ld_count, ld_ready);
        end
        beat(16'h1234, 1'b0);
        beat(16'h5678, 1'b1);
        cyc();
        fetch(16'h0002, 1'b1);
        n_tests++;
        if (idata !== 16'h5678 || ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_idx1: idata=%h ivalid=%b, need 5678 1", idata, ivalid);
        end
        fetch(16'h0004, 1'b1);
        n_tests++;
        if (idata !== 16'h0) begin
            n_fail++;
            $display("FAIL reload_idx2: idata=%h, need 0000", idata);
        end
    endtask

    task automatic test_ignored_start_and_reset();
        start_load();
        beat(16'hAAAA, 1'b0);
        ld_start = 1'b1;
        beat(16'hBBBB, 1'b0);
        ld_start = 1'b0;
        beat(16'hCCCC, 1'b0);
        n_tests++;
        if (ld_count !== 7'd3 || stall !== 1'b1 || ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_load: cnt=%0d stall=%b rdy=%b, need 3 1 1", ld_count, stall, ld_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (ld_count !== 7'd0 || stall !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load: cnt=%0d stall=%b rdy=%b, need 0 1 0", ld_count, stall, ld_ready);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        start_load();
        beat(16'h4321, 1'b1);
        fetch(16'h0002, 1'b1);
        n_tests++;
        if (idata !== 16'h0 || ivalid !== 1'b1) begin
            n_fail++;
            $display("FAIL one_word_idx1: idata=%h ivalid=%b, need 0000 1", idata, ivalid);
        end
        fetch(16'h0000, 1'b1);
        n_tests++;
        if (idata !== 16'h4321) begin
            n_fail++;
            $display("FAIL one_word_idx0: idata=%h, need 4321", idata);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n;
            bit ovf;
            n = $urandom_range(1, DEPTH);
            ovf = (n == DEPTH) && ($urandom_range(0, 1) == 1);
            start_load();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    cyc();
                beat(16'($urandom), i == n - 1 && !ovf);
            end
            n_tests++;
            if (ld_count !== 7'(m_count) || ld_err !== m_err || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_load: round %0d cnt=%0d err=%b stall=%b, need %0d %b 0", r, ld_count, ld_err, stall, m_count, m_err);
            end
            for (int k = 0; k < 16; k++) begin
                fetch(16'($urandom_range(0, 160)), $urandom_range(0, 3) != 0);
                n_tests++;
                if (idata !== exp_idata || ivalid !== exp_ivalid) begin
                    n_fail++;
                    $display("FAIL rand_fetch: round %0d addr=%h idata=%h ivalid=%b, need %h %b", r, iaddr, idata, ivalid, exp_idata, exp_ivalid);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_out_of_range();
        test_async_reset();
        test_overflow();
        test_reload();
        test_ignored_start_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
